// File: rtl/tnn_layer_sequencer.sv
// Sequences one shared TNN neuron core over NUM_NEURONS slots per input sample
// and packs the per-slot core decisions into a layer result vector.
module tnn_layer_sequencer #(
  parameter int unsigned NUM_IN      = 7,
  parameter int unsigned IN_W        = 2,
  parameter int unsigned NUM_NEURONS = 5,
  parameter int unsigned CORE_LAT    = 0,
  localparam int unsigned DATA_W     = NUM_IN * IN_W,
  localparam int unsigned SEL_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic [DATA_W-1:0]      core_data,
  output logic [SEL_W-1:0]       core_sel,
  input  logic                   core_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_vec,
  output logic                   busy
);

  localparam int unsigned WCNT_W = 3;
  localparam logic [WCNT_W-1:0] LAT       = WCNT_W'(CORE_LAT);
  localparam logic [SEL_W-1:0]  LAST_SLOT = SEL_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [WCNT_W-1:0]   wcnt;
  logic                accept;

  // Only combinational output: DONE lets a new sample in the same edge the result leaves.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      core_data <= '0;
      core_sel  <= '0;
      wcnt      <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            core_data <= in_data;
            out_vec   <= '0;
            core_sel  <= '0;
            wcnt      <= '0;
            busy      <= 1'b1;
            state     <= S_EVAL;
          end
        end

        S_EVAL: begin
          // wcnt counts up from zero, so inequality marks the settle cycles of a slot.
          if (wcnt != LAT) begin
            wcnt <= wcnt + 3'd1;
          end else begin
            out_vec[core_sel] <= core_out;
            wcnt              <= '0;
            if (core_sel == LAST_SLOT) begin
              core_sel  <= '0;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              core_sel <= core_sel + 1'b1;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              core_data <= in_data;
              out_vec   <= '0;
              core_sel  <= '0;
              wcnt      <= '0;
              busy      <= 1'b1;
              state     <= S_EVAL;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
